// File: rtl/mc_control_pkg.sv
// mc_control_pkg: shared encodings for the multi-cycle MIPS control unit.
//   - state_e     : FSM state encoding (3 bits)
//   - OP_* / FN_* : IR opcode and funct field values, RT_BGEZAL for REGIMM
//   - ALU_*, NPC_*, WD_*, RD_*, EXT_* : datapath select codes
//   - iclass_t    : one-hot instruction class produced by mc_decode
package mc_control_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_MDU    = 3'd5
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_XOR  = 6'h26;

  // REGIMM rt field selecting bgezal
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_OR    = 3'd2;
  localparam logic [2:0] ALU_XOR   = 3'd3;
  localparam logic [2:0] ALU_PASSB = 3'd4;

  // Next-PC source
  localparam logic [1:0] NPC_PC4 = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J26 = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  // Register-file write data source
  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_DM   = 2'd1;
  localparam logic [1:0] WD_PC4  = 2'd2;
  localparam logic [1:0] WD_HILO = 2'd3;

  // Register-file destination
  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  // Immediate extension
  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  // Exactly one bit is set for any IR value.
  typedef struct packed {
    logic addu;
    logic subu;
    logic xor_op;
    logic jr;
    logic mult;
    logic div;
    logic mfhi;
    logic mflo;
    logic beq;
    logic bgezal;
    logic lui;
    logic lw;
    logic ori;
    logic sw;
    logic j;
    logic jal;
    logic illegal;
  } iclass_t;

endpackage

// File: rtl/mc_control_decode.sv
// mc_decode: combinational instruction classifier.
//   op_i  [5:0] : IR[31:26]
//   fun_i [5:0] : IR[5:0]
//   rt_i  [4:0] : IR[20:16]
//   cls_o       : one-hot instruction class; unrecognised encodings set .illegal
module mc_decode
  import mc_control_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] fun_i,
  input  logic [4:0] rt_i,
  output iclass_t    cls_o
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cls_o = '0;
    case (op_i)
      OP_RTYPE: begin
        case (fun_i)
          FN_ADDU: cls_o.addu    = 1'b1;
          FN_SUBU: cls_o.subu    = 1'b1;
          FN_XOR:  cls_o.xor_op  = 1'b1;
          FN_JR:   cls_o.jr      = 1'b1;
          FN_MULT: cls_o.mult    = 1'b1;
          FN_DIV:  cls_o.div     = 1'b1;
          FN_MFHI: cls_o.mfhi    = 1'b1;
          FN_MFLO: cls_o.mflo    = 1'b1;
          default: cls_o.illegal = 1'b1;
        endcase
      end
      // Only bgezal is implemented within the REGIMM group.
      OP_REGIMM: begin
        if (rt_i == RT_BGEZAL) cls_o.bgezal  = 1'b1;
        else                   cls_o.illegal = 1'b1;
      end
      OP_J:    cls_o.j       = 1'b1;
      OP_JAL:  cls_o.jal     = 1'b1;
      OP_BEQ:  cls_o.beq     = 1'b1;
      OP_ORI:  cls_o.ori     = 1'b1;
      OP_LUI:  cls_o.lui     = 1'b1;
      OP_LW:   cls_o.lw      = 1'b1;
      OP_SW:   cls_o.sw      = 1'b1;
      default: cls_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/MDU).
//   Inputs : clk, reset (sync, active-high), op/fun/rt (IR fields),
//            alu_zero (beq), rs_gez (bgezal), mem_ready (DM handshake).
//   Outputs: pc_we, ir_we, npc_sel, regdst, wd_sel, alusrc, ext_op, alu_op,
//            regw, memr, memw, mdu_start, mdu_op, hilo_sel, busy, illegal.
//   Outputs are decoded from the current state and IR class; all are forced
//   to zero while reset is high so no strobe fires during an abort.
module mc_control
  import mc_control_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] fun,
  input  logic [4:0] rt,
  input  logic       alu_zero,
  input  logic       rs_gez,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       ir_we,
  output logic [1:0] npc_sel,
  output logic [1:0] regdst,
  output logic [1:0] wd_sel,
  output logic       alusrc,
  output logic [1:0] ext_op,
  output logic [2:0] alu_op,
  output logic       regw,
  output logic       memr,
  output logic       memw,
  output logic       mdu_start,
  output logic       mdu_op,
  output logic       hilo_sel,
  output logic       busy,
  output logic       illegal
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

  iclass_t          cls;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mdu_start_q, mdu_start_d;
  logic             mdu_op_q, mdu_op_d;

  mc_decode u_decode (
    .op_i  (op),
    .fun_i (fun),
    .rt_i  (rt),
    .cls_o (cls)
  );

  // ALU-class instructions (R-type arithmetic, ori, lui) share one operand setup.
  logic       is_rtype_alu, is_alu_cls;
  logic       alu_cls_src;
  logic [1:0] alu_cls_ext;
  logic [2:0] alu_cls_op;

  assign is_rtype_alu = cls.addu | cls.subu | cls.xor_op;
  assign is_alu_cls   = is_rtype_alu | cls.ori | cls.lui;
  assign alu_cls_src  = cls.ori | cls.lui;
  assign alu_cls_ext  = cls.lui ? EXT_LUI : EXT_ZERO;
  assign alu_cls_op   = cls.subu   ? ALU_SUB   :
                        cls.xor_op ? ALU_XOR   :
                        cls.ori    ? ALU_OR    :
                        cls.lui    ? ALU_PASSB : ALU_ADD;

  // Next-state and MDU counter logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mdu_start_d = 1'b0;
    mdu_op_d    = mdu_op_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (cls.j | cls.jal | cls.jr | cls.mfhi | cls.mflo | cls.illegal) state_d = S_FETCH;
        else                                                               state_d = S_EXEC;
      end
      S_EXEC: begin
        if (cls.beq | cls.bgezal)   state_d = S_FETCH;
        else if (cls.lw | cls.sw)   state_d = S_MEM;
        else if (cls.mult | cls.div) begin
          // Loading LAT-1 and leaving on zero gives exactly LAT cycles in S_MDU.
          state_d     = S_MDU;
          cnt_d       = cls.div ? DIV_LOAD : MULT_LOAD;
          mdu_start_d = 1'b1;
          mdu_op_d    = cls.div;
        end
        else                        state_d = S_WB;
      end
      S_MEM: begin
        if (mem_ready) state_d = cls.lw ? S_WB : S_FETCH;
      end
      S_WB:     state_d = S_FETCH;
      S_MDU: begin
        if (cnt_q == '0) state_d = S_FETCH;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q     <= S_FETCH;
      cnt_q       <= '0;
      mdu_start_q <= 1'b0;
      mdu_op_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mdu_start_q <= mdu_start_d;
      mdu_op_q    <= mdu_op_d;
    end
  end

  // Output decode; gated by reset because reset is synchronous and the state
  // register still holds the aborted state during the reset cycle.
  always_comb begin
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    npc_sel   = NPC_PC4;
    regdst    = RD_RT;
    wd_sel    = WD_ALU;
    alusrc    = 1'b0;
    ext_op    = EXT_ZERO;
    alu_op    = ALU_ADD;
    regw      = 1'b0;
    memr      = 1'b0;
    memw      = 1'b0;
    mdu_start = 1'b0;
    mdu_op    = 1'b0;
    hilo_sel  = 1'b0;
    busy      = 1'b0;
    illegal   = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          npc_sel = NPC_PC4;
        end
        S_DECODE: begin
          if (cls.j | cls.jal) begin
            pc_we   = 1'b1;
            npc_sel = NPC_J26;
          end
          if (cls.jal) begin
            regw   = 1'b1;
            regdst = RD_RA;
            wd_sel = WD_PC4;
          end
          if (cls.jr) begin
            pc_we   = 1'b1;
            npc_sel = NPC_JR;
          end
          if (cls.mfhi | cls.mflo) begin
            regw     = 1'b1;
            regdst   = RD_RD;
            wd_sel   = WD_HILO;
            hilo_sel = cls.mfhi;
          end
          illegal = cls.illegal;
        end
        S_EXEC: begin
          if (cls.beq) begin
            pc_we   = alu_zero;
            npc_sel = NPC_BR;
            alu_op  = ALU_SUB;
          end
          // bgezal links unconditionally; only the PC update depends on the test.
          if (cls.bgezal) begin
            pc_we   = rs_gez;
            npc_sel = NPC_BR;
            regw    = 1'b1;
            regdst  = RD_RA;
            wd_sel  = WD_PC4;
          end
          if (cls.lw | cls.sw) begin
            alu_op = ALU_ADD;
            alusrc = 1'b1;
            ext_op = EXT_SIGN;
          end
          if (is_alu_cls) begin
            alu_op = alu_cls_op;
            alusrc = alu_cls_src;
            ext_op = alu_cls_ext;
          end
        end
        S_MEM: begin
          memr = cls.lw;
          memw = cls.sw;
        end
        S_WB: begin
          regw   = 1'b1;
          wd_sel = cls.lw ? WD_DM : WD_ALU;
          regdst = is_rtype_alu ? RD_RD : RD_RT;
          if (is_alu_cls) begin
            alu_op = alu_cls_op;
            alusrc = alu_cls_src;
            ext_op = alu_cls_ext;
          end
        end
        S_MDU: begin
          busy      = 1'b1;
          mdu_start = mdu_start_q;
          mdu_op    = mdu_op_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: randomized self-checking bench for mc_control.
// Each instruction is expanded into its list of phases (F, D, E, M, W, U)
// from the instruction's cycle rules; per-cycle expected outputs come from
// the phase and instruction kind. Strobes/enables are checked on every cycle,
// selects only where they carry meaning.
module tb_mc_control;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, fun;
  logic [4:0] rt;
  logic       alu_zero, rs_gez, mem_ready;
  logic       pc_we, ir_we, alusrc, regw, memr, memw;
  logic       mdu_start, mdu_op, hilo_sel, busy, illegal;
  logic [1:0] npc_sel, regdst, wd_sel, ext_op;
  logic [2:0] alu_op;

  always #5 clk = ~clk;

  mc_control #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .fun       (fun),
    .rt        (rt),
    .alu_zero  (alu_zero),
    .rs_gez    (rs_gez),
    .mem_ready (mem_ready),
    .pc_we     (pc_we),
    .ir_we     (ir_we),
    .npc_sel   (npc_sel),
    .regdst    (regdst),
    .wd_sel    (wd_sel),
    .alusrc    (alusrc),
    .ext_op    (ext_op),
    .alu_op    (alu_op),
    .regw      (regw),
    .memr      (memr),
    .memw      (memw),
    .mdu_start (mdu_start),
    .mdu_op    (mdu_op),
    .hilo_sel  (hilo_sel),
    .busy      (busy),
    .illegal   (illegal)
  );

  typedef enum int {K_ADDU, K_SUBU, K_XOR, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_BGEZAL,
                    K_J, K_JAL, K_JR, K_MFHI, K_MFLO, K_MULT, K_DIV, K_ILL} kind_e;
  typedef enum int {P_F, P_D, P_E, P_M, P_W, P_U} phase_e;

  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic [1:0] npc_sel;
    logic [1:0] regdst;
    logic [1:0] wd_sel;
    logic       alusrc;
    logic [1:0] ext_op;
    logic [2:0] alu_op;
    logic       regw;
    logic       memr;
    logic       memw;
    logic       mdu_start;
    logic       mdu_op;
    logic       hilo_sel;
    logic       busy;
    logic       illegal;
  } ovec_t;

  int     n_checks = 0;
  int     n_err    = 0;
  int     ill_var  = 0;
  phase_e ph_q[$];
  int     k_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %06h expected %06h", tag, got, exp);
    end
  endtask

  function automatic ovec_t observe();
    ovec_t o;
    o = '{pc_we, ir_we, npc_sel, regdst, wd_sel, alusrc, ext_op, alu_op,
          regw, memr, memw, mdu_start, mdu_op, hilo_sel, busy, illegal};
    return o;
  endfunction

  function automatic bit is_rtype_alu(kind_e k);
    return (k == K_ADDU) || (k == K_SUBU) || (k == K_XOR);
  endfunction

  // Drive IR fields; fields an instruction does not use are left random.
  task automatic encode(input kind_e k);
    op  = 6'($urandom);
    fun = 6'($urandom);
    rt  = 5'($urandom);
    case (k)
      K_ADDU:   begin op = 6'h00; fun = 6'h21; end
      K_SUBU:   begin op = 6'h00; fun = 6'h23; end
      K_XOR:    begin op = 6'h00; fun = 6'h26; end
      K_JR:     begin op = 6'h00; fun = 6'h08; end
      K_MFHI:   begin op = 6'h00; fun = 6'h10; end
      K_MFLO:   begin op = 6'h00; fun = 6'h12; end
      K_MULT:   begin op = 6'h00; fun = 6'h18; end
      K_DIV:    begin op = 6'h00; fun = 6'h1A; end
      K_ORI:    op = 6'h0D;
      K_LUI:    op = 6'h0F;
      K_LW:     op = 6'h23;
      K_SW:     op = 6'h2B;
      K_BEQ:    op = 6'h04;
      K_J:      op = 6'h02;
      K_JAL:    op = 6'h03;
      K_BGEZAL: begin op = 6'h01; rt = 5'h11; end
      default: begin
        case (ill_var)
          0:       op = 6'h3F;
          1:       begin op = 6'h00; fun = 6'h3F; end
          2:       begin op = 6'h01; rt = 5'h00; end
          default: op = 6'h08;
        endcase
      end
    endcase
  endtask

  // Phase sequence of one instruction; w = memory wait cycles before mem_ready.
  task automatic build_phases(input kind_e k, input int w);
    ph_q.delete();
    k_q.delete();
    ph_q.push_back(P_F); k_q.push_back(0);
    ph_q.push_back(P_D); k_q.push_back(0);
    if (k inside {K_J, K_JAL, K_JR, K_MFHI, K_MFLO, K_ILL}) return;
    ph_q.push_back(P_E); k_q.push_back(0);
    if (k inside {K_BEQ, K_BGEZAL}) return;
    if (k inside {K_LW, K_SW}) begin
      for (int i = 0; i <= w; i++) begin ph_q.push_back(P_M); k_q.push_back(i); end
      if (k == K_LW) begin ph_q.push_back(P_W); k_q.push_back(0); end
      return;
    end
    if (k inside {K_MULT, K_DIV}) begin
      for (int i = 0; i < ((k == K_DIV) ? DIV_LAT : MULT_LAT); i++) begin
        ph_q.push_back(P_U); k_q.push_back(i);
      end
      return;
    end
    ph_q.push_back(P_W); k_q.push_back(0);
  endtask

  function automatic void expect_cycle(input kind_e k, input phase_e ph, input int idx,
                                       input logic az, input logic gez,
                                       output ovec_t e, output ovec_t m);
    e = '0;
    m = '0;
    m.pc_we = 1; m.ir_we = 1; m.regw = 1; m.memr = 1; m.memw = 1;
    m.mdu_start = 1; m.busy = 1; m.illegal = 1;
    case (ph)
      P_F: begin e.pc_we = 1; e.ir_we = 1; m.npc_sel = '1; end
      P_D: begin
        case (k)
          K_J:   begin e.pc_we = 1; e.npc_sel = 2; m.npc_sel = '1; end
          K_JR:  begin e.pc_we = 1; e.npc_sel = 3; m.npc_sel = '1; end
          K_JAL: begin
            e.pc_we = 1; e.npc_sel = 2; e.regw = 1; e.regdst = 2; e.wd_sel = 2;
            m.npc_sel = '1; m.regdst = '1; m.wd_sel = '1;
          end
          K_MFHI, K_MFLO: begin
            e.regw = 1; e.regdst = 1; e.wd_sel = 3; e.hilo_sel = (k == K_MFHI);
            m.regdst = '1; m.wd_sel = '1; m.hilo_sel = 1;
          end
          K_ILL: e.illegal = 1;
          default: ;
        endcase
      end
      P_E: begin
        case (k)
          K_BEQ: begin
            e.pc_we = az; e.npc_sel = 1; e.alu_op = 1;
            m.npc_sel = '1; m.alu_op = '1;
          end
          K_BGEZAL: begin
            e.pc_we = gez; e.npc_sel = 1; e.regw = 1; e.regdst = 2; e.wd_sel = 2;
            m.npc_sel = '1; m.regdst = '1; m.wd_sel = '1;
          end
          K_LW, K_SW: begin
            e.alu_op = 0; e.alusrc = 1; e.ext_op = 1;
            m.alu_op = '1; m.alusrc = 1; m.ext_op = '1;
          end
          default: ;
        endcase
      end
      P_M: begin e.memr = (k == K_LW); e.memw = (k == K_SW); end
      P_W: begin
        e.regw = 1;
        e.wd_sel = (k == K_LW) ? 2'd1 : 2'd0;
        e.regdst = is_rtype_alu(k) ? 2'd1 : 2'd0;
        m.wd_sel = '1; m.regdst = '1;
        m.alu_op = '1; m.alusrc = 1; m.ext_op = '1;
        case (k)
          K_ADDU: e.alu_op = 0;
          K_SUBU: e.alu_op = 1;
          K_XOR:  e.alu_op = 3;
          K_ORI:  begin e.alu_op = 2; e.alusrc = 1; e.ext_op = 0; end
          K_LUI:  begin e.alu_op = 4; e.alusrc = 1; e.ext_op = 2; end
          default: begin m.alu_op = '0; m.alusrc = 0; m.ext_op = '0; end
        endcase
      end
      P_U: begin
        e.busy = 1;
        e.mdu_start = (idx == 0);
        if (idx == 0) begin m.mdu_op = 1; e.mdu_op = (k == K_DIV); end
      end
      default: ;
    endcase
  endfunction

  // Run one instruction from a negedge. az/gez mode: 0/1 fixed, 2 random.
  // abort_at >= 0 asserts reset on that cycle of the instruction and stops.
  task automatic run_instr(input kind_e k, input int w, input int az_mode,
                           input int gez_mode, input int abort_at, input string tag);
    ovec_t e, m, o;
    build_phases(k, w);
    encode(k);
    for (int i = 0; i < ph_q.size(); i++) begin
      alu_zero = (az_mode == 2)  ? 1'($urandom) : 1'(az_mode);
      rs_gez   = (gez_mode == 2) ? 1'($urandom) : 1'(gez_mode);
      mem_ready = (ph_q[i] == P_M) ? (k_q[i] == w) : 1'($urandom);
      if (i == abort_at) begin
        reset = 1'b1;
        #2;
        o = observe();
        m = '1;
        m.busy = 0;
        check($sformatf("%s abort c%0d", tag, i), 32'(o & m), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      #2;
      o = observe();
      expect_cycle(k, ph_q[i], k_q[i], alu_zero, rs_gez, e, m);
      check($sformatf("%s c%0d ph%0d", tag, i, ph_q[i]), 32'(o & m), 32'(e & m));
      @(negedge clk);
    end
  endtask

  initial begin
    ovec_t o, m;
    kind_e k;
    reset = 1'b1; op = '0; fun = '0; rt = '0;
    alu_zero = 1'b0; rs_gez = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    // Reset held two cycles: every output except busy must be zero.
    for (int i = 0; i < 2; i++) begin
      op = 6'($urandom); fun = 6'($urandom); mem_ready = 1'($urandom);
      #2;
      o = observe();
      m = '1; m.busy = 0;
      check($sformatf("reset c%0d", i), 32'(o & m), 32'(0));
      @(negedge clk);
    end
    reset = 1'b0;

    // Directed scenarios.
    run_instr(K_ADDU,   0, 2, 2, -1, "addu");
    run_instr(K_LW,     3, 2, 2, -1, "lw_wait3");
    run_instr(K_BEQ,    0, 1, 2, -1, "beq_taken");
    run_instr(K_BEQ,    0, 0, 2, -1, "beq_not");
    run_instr(K_BGEZAL, 0, 2, 0, -1, "bgezal_nt");
    run_instr(K_DIV,    0, 2, 2, -1, "div");
    run_instr(K_DIV,    0, 2, 2,  6, "div_rst");
    run_instr(K_ADDU,   0, 2, 2, -1, "after_div_rst");
    ill_var = 0;
    run_instr(K_ILL,    0, 2, 2, -1, "ill_3f");
    run_instr(K_JAL,    0, 2, 2, -1, "jal");
    run_instr(K_LW,     3, 2, 2,  4, "lw_rst");
    run_instr(K_SW,     2, 2, 2, -1, "sw_wait2");
    run_instr(K_MULT,   0, 2, 2, -1, "mult");

    // Randomized instruction stream.
    for (int n = 0; n < 250; n++) begin
      k = kind_e'($urandom_range(0, 16));
      ill_var = int'($urandom_range(0, 3));
      run_instr(k, int'($urandom_range(0, 4)), 2, 2,
                ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : -1,
                $sformatf("rnd%0d_k%0d", n, k));
    end
    // Closing fetch after the last instruction.
    run_instr(K_J, 0, 2, 2, -1, "final_j");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
